// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destination tags, produces a
// registered per-port EX bypass select and a combinational load-use stall.
module hazard_forward_unit #(
    parameter int  NUM_RD_PORTS = 2,
    parameter int  REG_ADDR_W   = 5,
    parameter int  DEPTH        = 3,
    parameter int  LOAD_STAGE   = 3,
    localparam int SEL_W        = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic                               id_regW_en,
    input  logic                               id_is_load,
    input  logic [REG_ADDR_W-1:0]              id_regD,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_RD_PORTS-1:0]            id_src_used,
    input  logic                               flush,
    output logic                               stall,
    output logic [NUM_RD_PORTS*SEL_W-1:0]      ex_fwd_sel,
    output logic [15:0]                        stall_cnt
);
    // The WB entry never produces a select (register file is write-through),
    // so only stages 1..DEPTH-1 are stored.
    localparam int TRK = DEPTH - 1;

    logic                  tag_vld_p  [1:TRK];
    logic                  tag_wen_p  [1:TRK];
    logic                  tag_load_p [1:TRK];
    logic [REG_ADDR_W-1:0] tag_rd_p   [1:TRK];

    logic [NUM_RD_PORTS-1:0]       port_found;
    logic [NUM_RD_PORTS-1:0]       port_haz;
    logic [NUM_RD_PORTS*SEL_W-1:0] sel_nxt;
    logic                          advance;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ID stage: compare sources against tracked producers, youngest first
    always_comb begin
        port_found = '0;
        port_haz   = '0;
        sel_nxt    = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            for (int s = 1; s <= TRK; s++) begin
                if (!port_found[r] && id_src_used[r] && tag_vld_p[s] && tag_wen_p[s] &&
                    (tag_rd_p[s] != '0) &&
                    (tag_rd_p[s] == id_src[r*REG_ADDR_W +: REG_ADDR_W])) begin
                    port_found[r]              = 1'b1;
                    sel_nxt[r*SEL_W +: SEL_W]  = SEL_W'(s + 1);
                    port_haz[r]                = tag_load_p[s] && ((s + 1) < LOAD_STAGE);
                end
            end
        end
    end

    assign stall   = (|port_haz) && !rst && !flush;
    assign advance = id_valid && !stall && !flush;

    // ID -> EX boundary: control state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= TRK; s++) begin
                tag_vld_p[s] <= 1'b0;
            end
            ex_fwd_sel <= '0;
            stall_cnt  <= '0;
        end else begin
            tag_vld_p[1] <= advance;
            for (int s = 2; s <= TRK; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
            end
            ex_fwd_sel <= advance ? sel_nxt : '0;
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // ID -> EX boundary: tag payload, qualified by the valid bits above
    always_ff @(posedge clk) begin
        tag_wen_p[1]  <= id_regW_en;
        tag_load_p[1] <= id_is_load;
        tag_rd_p[1]   <= id_regD;
        for (int s = 2; s <= TRK; s++) begin
            tag_wen_p[s]  <= tag_wen_p[s-1];
            tag_load_p[s] <= tag_load_p[s-1];
            tag_rd_p[s]   <= tag_rd_p[s-1];
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios plus
// randomized traffic compared against an instruction-level reference model.
module tb_hazard_forward_unit;
    localparam int NP = 2;
    localparam int W  = 5;
    localparam int D  = 3;
    localparam int LS = 3;
    localparam int SW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_regW_en, id_is_load, flush;
    logic [W-1:0]    id_regD;
    logic [NP*W-1:0] id_src;
    logic [NP-1:0]   id_src_used;
    logic            stall;
    logic [NP*SW-1:0] ex_fwd_sel;
    logic [15:0]     stall_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: one record per in-flight instruction, stage 1..D
    bit       mv [1:D];
    bit       mw [1:D];
    bit       ml [1:D];
    bit [W-1:0] mr [1:D];
    int       msel [NP];
    int       mcnt;
    bit       e_stall;
    int       e_nsel [NP];

    typedef struct {
        bit v, w, l;
        int rd, s0, s1;
        bit [1:0] u;
        int x0, x1, xst;
    } ins_t;

    hazard_forward_unit #(
        .NUM_RD_PORTS(NP), .REG_ADDR_W(W), .DEPTH(D), .LOAD_STAGE(LS)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regW_en(id_regW_en),
        .id_is_load(id_is_load), .id_regD(id_regD), .id_src(id_src),
        .id_src_used(id_src_used), .flush(flush), .stall(stall),
        .ex_fwd_sel(ex_fwd_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(bit v, bit w, bit l, int rd, int s0, int s1, bit [1:0] u,
                                int x0, int x1, int xst);
        ins_t t;
        t.v = v; t.w = w; t.l = l; t.rd = rd; t.s0 = s0; t.s1 = s1; t.u = u;
        t.x0 = x0; t.x1 = x1; t.xst = xst;
        return t;
    endfunction

    task automatic drive(bit v, bit w, bit l, int rd, int s0, int s1, bit [1:0] u, bit fl);
        id_valid    = v;
        id_regW_en  = w;
        id_is_load  = l;
        id_regD     = W'(rd);
        id_src      = {W'(s1), W'(s0)};
        id_src_used = u;
        flush       = fl;
    endtask

    // Expected stall and next selects from the current ID instruction and in-flight list.
    // Scanning oldest to youngest and overwriting leaves the youngest producer.
    task automatic predict();
        bit haz;
        e_stall = 1'b0;
        for (int r = 0; r < NP; r++) begin
            int src;
            src = int'(id_src[r*W +: W]);
            e_nsel[r] = 0;
            haz = 1'b0;
            if (id_src_used[r] && src != 0) begin
                for (int s = D - 1; s >= 1; s--) begin
                    if (mv[s] && mw[s] && int'(mr[s]) == src) begin
                        e_nsel[r] = s + 1;
                        haz = ml[s] && ((s + 1) < LS);
                    end
                end
            end
            if (haz) e_stall = 1'b1;
        end
        if (rst || flush) e_stall = 1'b0;
    endtask

    task automatic step();
        bit adv;
        bit was_rst;
        adv = id_valid && !e_stall && !flush;
        was_rst = rst;
        @(posedge clk);
        if (was_rst) begin
            for (int s = 1; s <= D; s++) mv[s] = 1'b0;
            for (int r = 0; r < NP; r++) msel[r] = 0;
            mcnt = 0;
        end else begin
            for (int s = D; s >= 2; s--) begin
                mv[s] = mv[s-1]; mw[s] = mw[s-1]; ml[s] = ml[s-1]; mr[s] = mr[s-1];
            end
            mv[1] = adv; mw[1] = id_regW_en; ml[1] = id_is_load; mr[1] = id_regD;
            for (int r = 0; r < NP; r++) msel[r] = adv ? e_nsel[r] : 0;
            if (e_stall && mcnt < 65535) mcnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'b0);
            #1;
            predict();
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL reset_stall got %0b exp 0", stall);
            end
            step();
            checks++;
            if (ex_fwd_sel !== '0) begin
                errors++; $display("FAIL reset_sel got %0h exp 0", ex_fwd_sel);
            end
            checks++;
            if (stall_cnt !== 16'd0) begin
                errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt);
            end
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1, 1, 2, 2'b11, 1'b0);
        #1;
        predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_first_stall got %0b exp 0", stall);
        end
        step();
    endtask

    task automatic test_directed();
        ins_t p[$];
        ins_t nop;
        int   nst;
        bit   obs;
        nop = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        repeat (3) p.push_back(nop);
        p.push_back(mk(1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0));   // add r3
        p.push_back(mk(1, 1, 0, 4, 3, 1, 2'b11, 2, 0, 0));   // add r4,r3,r1
        repeat (3) p.push_back(nop);
        p.push_back(mk(1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0));   // add r3
        p.push_back(nop);
        p.push_back(mk(1, 1, 0, 5, 1, 3, 2'b11, 0, 3, 0));   // sub r5,r1,r3
        repeat (3) p.push_back(nop);
        p.push_back(mk(1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0));   // add r3
        p.push_back(nop);
        p.push_back(nop);
        p.push_back(mk(1, 1, 0, 6, 3, 3, 2'b11, 0, 0, 0));   // or r6,r3,r3
        repeat (3) p.push_back(nop);
        p.push_back(mk(1, 1, 1, 5, 0, 0, 2'b00, 0, 0, 0));   // lw r5
        p.push_back(mk(1, 1, 0, 7, 5, 2, 2'b11, 3, 0, 1));   // add r7,r5,r2
        repeat (3) p.push_back(nop);
        p.push_back(mk(1, 1, 0, 2, 0, 0, 2'b00, 0, 0, 0));   // add r2 (older)
        p.push_back(mk(1, 1, 0, 2, 0, 0, 2'b00, 0, 0, 0));   // add r2 (younger)
        p.push_back(mk(1, 1, 0, 8, 2, 2, 2'b11, 2, 2, 0));   // add r8,r2,r2
        repeat (3) p.push_back(nop);
        p.push_back(mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0));   // lw r0
        p.push_back(mk(1, 1, 0, 9, 0, 0, 2'b11, 0, 0, 0));   // add r9,r0,r0
        repeat (3) p.push_back(nop);

        foreach (p[i]) begin
            nst = 0;
            for (int k = 0; k < 5; k++) begin
                drive(p[i].v, p[i].w, p[i].l, p[i].rd, p[i].s0, p[i].s1, p[i].u, 1'b0);
                #1;
                predict();
                checks++;
                if (stall !== e_stall) begin
                    errors++; $display("FAIL dir_stall row %0d got %0b exp %0b", i, stall, e_stall);
                end
                obs = stall;
                step();
                for (int r = 0; r < NP; r++) begin
                    checks++;
                    if (ex_fwd_sel[r*SW +: SW] !== SW'(msel[r])) begin
                        errors++;
                        $display("FAIL dir_model_sel row %0d port %0d got %0d exp %0d",
                                 i, r, ex_fwd_sel[r*SW +: SW], msel[r]);
                    end
                end
                checks++;
                if (stall_cnt !== 16'(mcnt)) begin
                    errors++; $display("FAIL dir_cnt row %0d got %0d exp %0d", i, stall_cnt, mcnt);
                end
                if (!obs) break;
                nst++;
            end
            checks++;
            if (nst != p[i].xst) begin
                errors++; $display("FAIL dir_stall_cycles row %0d got %0d exp %0d", i, nst, p[i].xst);
            end
            checks++;
            if (ex_fwd_sel !== {SW'(p[i].x1), SW'(p[i].x0)}) begin
                errors++;
                $display("FAIL dir_sel row %0d got %0h exp p1=%0d p0=%0d", i, ex_fwd_sel, p[i].x1, p[i].x0);
            end
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL dir_total_stalls got %0d exp 1", stall_cnt);
        end
    endtask

    task automatic test_flush_reset();
        drive(1, 1, 1, 5, 0, 0, 2'b00, 1'b0);                 // lw r5
        #1; predict(); step();
        drive(1, 1, 0, 7, 5, 2, 2'b11, 1'b1);                 // dependent, flushed
        #1; predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall got %0b exp 0", stall);
        end
        step();
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL flush_cnt got %0d exp 1", stall_cnt);
        end
        checks++;
        if (ex_fwd_sel !== '0) begin
            errors++; $display("FAIL flush_sel got %0h exp 0", ex_fwd_sel);
        end
        drive(1, 1, 1, 5, 0, 0, 2'b00, 1'b0);                 // lw r5
        #1; predict(); step();
        drive(1, 1, 0, 7, 5, 2, 2'b11, 1'b0);
        rst = 1'b1;                                           // reset during the hazard
        #1; predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL rst_stall got %0b exp 0", stall);
        end
        step();
        checks++;
        if (ex_fwd_sel !== '0) begin
            errors++; $display("FAIL rst_sel got %0h exp 0", ex_fwd_sel);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt);
        end
        rst = 1'b0;
        #1; predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL post_rst_stall got %0b exp 0", stall);
        end
        step();
        checks++;
        if (ex_fwd_sel !== '0) begin
            errors++; $display("FAIL post_rst_sel got %0h exp 0", ex_fwd_sel);
        end
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            end else begin
                flush = ($urandom_range(0, 7) == 0);
            end
            rst = ($urandom_range(0, 59) == 0);
            #1;
            predict();
            checks++;
            if (stall !== e_stall) begin
                errors++; $display("FAIL rnd_stall cyc %0d got %0b exp %0b", i, stall, e_stall);
            end
            hold = e_stall;
            step();
            for (int r = 0; r < NP; r++) begin
                checks++;
                if (ex_fwd_sel[r*SW +: SW] !== SW'(msel[r])) begin
                    errors++;
                    $display("FAIL rnd_sel cyc %0d port %0d got %0d exp %0d",
                             i, r, ex_fwd_sel[r*SW +: SW], msel[r]);
                end
            end
            checks++;
            if (stall_cnt !== 16'(mcnt)) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, stall_cnt, mcnt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int s = 1; s <= D; s++) begin
            mv[s] = 1'b0; mw[s] = 1'b0; ml[s] = 1'b0; mr[s] = '0;
        end
        for (int r = 0; r < NP; r++) msel[r] = 0;
        mcnt = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        test_reset();
        test_directed();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached without completing the bench");
        $fatal(1);
    end

endmodule
